// File: rtl/id_match_counter_if.sv
// Bus for id_match_counter: the match flag and clear from the upstream side,
// plus the run status/statistics returned by the counter.
// Optional history read port is present only when ID_MATCH_HIST_EN is defined.
//
// Handshake: there is no ready. done is a one-cycle valid strobe. done_len,
// max_len and match_cnt are all stable while done is high, so a consumer
// must capture them in that cycle. done_len then holds until the next done.
interface id_match_counter_if #(
   parameter int CNT_W = 8,
   parameter int LEN_W = 4
) ();
   logic             clear;
   logic             id_hit;
   logic             busy;
   logic [CNT_W-1:0] match_cnt;
   logic [LEN_W-1:0] run_len;
   logic             done;
   logic [LEN_W-1:0] done_len;
   logic [LEN_W-1:0] max_len;
   logic             dbg_state;
`ifdef ID_MATCH_HIST_EN
   logic [1:0]       hist_idx;
   logic [LEN_W-1:0] hist_len;
   logic [2:0]       hist_cnt;

   modport master (
      output clear, id_hit, hist_idx,
      input  busy, match_cnt, run_len, done, done_len, max_len, dbg_state,
             hist_len, hist_cnt
   );
   modport slave (
      input  clear, id_hit, hist_idx,
      output busy, match_cnt, run_len, done, done_len, max_len, dbg_state,
             hist_len, hist_cnt
   );
`else
   modport master (
      output clear, id_hit,
      input  busy, match_cnt, run_len, done, done_len, max_len, dbg_state
   );
   modport slave (
      input  clear, id_hit,
      output busy, match_cnt, run_len, done, done_len, max_len, dbg_state
   );
`endif
endinterface

// File: rtl/id_match_counter.sv
// id_match_counter: counts runs of the identifier FSM's match flag,
// measures each run's length, and reports per-run completion plus the
// longest run seen. All counters saturate rather than wrap.
// Optional feature macro ID_MATCH_HIST_EN adds a 4-entry history of
// completed run lengths (entry 0 = newest) with a registered read port.
module id_match_counter #(
   parameter int CNT_W = 8,
   parameter int LEN_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   id_match_counter_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] match_cnt;
   logic [LEN_W-1:0] run_len;
   logic             done;
   logic [LEN_W-1:0] done_len;
   logic [LEN_W-1:0] max_len;

   // Run tracking FSM; clear wins over id_hit and drops any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         match_cnt <= '0;
         run_len   <= '0;
         done      <= 1'b0;
         done_len  <= '0;
         max_len   <= '0;
      end else if (bus.clear) begin
         state     <= IDLE;
         match_cnt <= '0;
         run_len   <= '0;
         done      <= 1'b0;
         done_len  <= '0;
         max_len   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.id_hit) begin
                  state   <= RUN;
                  run_len <= LEN_W'(1);
                  if (match_cnt != CNT_MAX) begin
                     match_cnt <= match_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (bus.id_hit) begin
                  if (run_len != LEN_MAX) begin
                     run_len <= run_len + 1'b1;
                  end
               end else begin
                  state    <= IDLE;
                  done     <= 1'b1;
                  done_len <= run_len;
                  max_len  <= (run_len > max_len) ? run_len : max_len;
                  run_len  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.dbg_state = logic'(state);
   assign bus.match_cnt = match_cnt;
   assign bus.run_len   = run_len;
   assign bus.done      = done;
   assign bus.done_len  = done_len;
   assign bus.max_len   = max_len;

`ifdef ID_MATCH_HIST_EN
   logic [LEN_W-1:0] hist_mem [4];
   logic [2:0]       hist_cnt;
   logic [LEN_W-1:0] hist_len;
   logic             run_end;

   // Same condition that raises done on this edge.
   assign run_end = (state == RUN) && !bus.id_hit && !bus.clear;

   // History shift register (newest at 0) and registered read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) hist_mem[i] <= '0;
         hist_cnt <= '0;
         hist_len <= '0;
      end else if (bus.clear) begin
         for (int i = 0; i < 4; i++) hist_mem[i] <= '0;
         hist_cnt <= '0;
         hist_len <= '0;
      end else begin
         if (run_end) begin
            hist_mem[0] <= run_len;
            for (int i = 1; i < 4; i++) hist_mem[i] <= hist_mem[i-1];
            if (hist_cnt != 3'd4) begin
               hist_cnt <= hist_cnt + 1'b1;
            end
         end
         hist_len <= ({1'b0, bus.hist_idx} < hist_cnt) ? hist_mem[bus.hist_idx] : '0;
      end
   end

   assign bus.hist_cnt = hist_cnt;
   assign bus.hist_len = hist_len;
`endif

endmodule

// File: tb/tb_id_match_counter.sv
// Bench for id_match_counter: directed scenarios plus randomized runs.
// The reference model works at the level of "runs": each run of length L
// yields one completion report with min(L,15), the running count
// (saturating at 255) and the running maximum.
module tb_id_match_counter;

   localparam int CNT_W   = 8;
   localparam int LEN_W   = 4;
   localparam int LEN_MAX = 15;
   localparam int CNT_MAX = 255;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_match_counter_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

   id_match_counter #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];   // {match_cnt, max_len, done_len}
   int m_cnt = 0;
   int m_max = 0;
   int hist_q[$];           // newest first, at most 4

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_max = 0;
      hist_q.delete();
   endtask

   // ---------------- driver ----------------
   // One run of len cycles of id_hit=1 followed by gap cycles of 0 (gap>=1).
   task automatic run(input int len, input int gap);
      int l;
      l = (len > LEN_MAX) ? LEN_MAX : len;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (l > m_max) m_max = l;
      exp_q.push_back({m_cnt[7:0], m_max[3:0], l[3:0]});
      hist_q.push_front(l);
      if (hist_q.size() > 4) void'(hist_q.pop_back());
      bus.id_hit = 1'b1;
      for (int i = 1; i <= len; i++) begin
         tick();
         check("busy_in_run", int'(bus.busy), 1);
         check("run_len", int'(bus.run_len), (i > LEN_MAX) ? LEN_MAX : i);
         check("match_cnt", int'(bus.match_cnt), m_cnt);
      end
      bus.id_hit = 1'b0;
      tick();
      check("busy_after_run", int'(bus.busy), 0);
      check("run_len_idle", int'(bus.run_len), 0);
      check("max_len_after_run", int'(bus.max_len), m_max);
      for (int i = 1; i < gap; i++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      int'(bus.busy), 0);
      check({tag, "_match_cnt"}, int'(bus.match_cnt), 0);
      check({tag, "_run_len"},   int'(bus.run_len), 0);
      check({tag, "_done"},      int'(bus.done), 0);
      check({tag, "_done_len"},  int'(bus.done_len), 0);
      check({tag, "_max_len"},   int'(bus.max_len), 0);
   endtask

`ifdef ID_MATCH_HIST_EN
   task automatic hist_check();
      for (int idx = 0; idx < 4; idx++) begin
         bus.hist_idx = 2'(idx);
         tick();
         check("hist_len", int'(bus.hist_len), (idx < hist_q.size()) ? hist_q[idx] : 0);
         check("hist_cnt", int'(bus.hist_cnt), hist_q.size());
      end
   endtask
`endif

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [15:0] e;
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("done_len", int'(bus.done_len), int'(e[3:0]));
            check("done_max_len", int'(bus.max_len), int'(e[7:4]));
            check("done_match_cnt", int'(bus.match_cnt), int'(e[15:8]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.clear  = 1'b0;
      bus.id_hit = 1'b0;
`ifdef ID_MATCH_HIST_EN
      bus.hist_idx = 2'd0;
`endif
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // single run of 3
      run(3, 2);

      // runs of 2, 5, 1
      run(2, 1);
      run(5, 1);
      run(1, 2);
      check("max_len_5", int'(bus.max_len), 5);
      check("cnt_4", int'(bus.match_cnt), 4);
`ifdef ID_MATCH_HIST_EN
      hist_check();
`endif

      // long run saturates run_len
      run(20, 2);

      // clear during a run of 4
      bus.id_hit = 1'b1;
      repeat (3) tick();
      check("busy_before_clear", int'(bus.busy), 1);
      bus.clear = 1'b1;
      tick();
      bus.clear  = 1'b0;
      bus.id_hit = 1'b0;
      model_reset();
      check_all_zero("clear");
      repeat (3) tick();

`ifdef ID_MATCH_HIST_EN
      run(1, 1);
      run(2, 1);
      hist_check();
      run(3, 1);
      run(4, 1);
      run(5, 2);
      hist_check();
`endif

      // async reset in the middle of a run
      run(6, 1);
      bus.id_hit = 1'b1;
      repeat (3) tick();
      check("busy_before_reset", int'(bus.busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      bus.id_hit = 1'b0;
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check_all_zero("after_reset");

      // randomized runs
      for (int k = 0; k < 30; k++) begin
         run($urandom_range(1, 18), $urandom_range(1, 3));
      end

      // saturate match_cnt
      for (int k = 0; k < 260; k++) run(1, 1);
      check("cnt_saturated", int'(bus.match_cnt), CNT_MAX);
      run(4, 2);

      repeat (4) tick();
      check("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
